// File: rtl/sram_pkg.sv
// Shared types and constants for the asynchronous SRAM controller.
package sram_pkg;

    localparam int ADDR_W              = 19;
    localparam int DATA_W              = 16;
    localparam int CNT_W               = 4;
    localparam int WAIT_CYCLES_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } state_t;

endpackage

// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller: IDLE -> SETUP -> ACCESS x WAIT_CYCLES -> HOLD.
// Optional macro SRAM_CTRL_PERF_EN adds rd_count/wr_count completion counters.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ADR,
    output logic [DATA_W-1:0] DAT_O,
    output logic              DAT_OE,
    input  logic [DATA_W-1:0] DAT_I,
    output logic              RAMOE,
    output logic              RAMWE,
    output logic              RAMCS
`ifdef SRAM_CTRL_PERF_EN
    ,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
`endif
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic               accept;
    logic               last_access;

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        accept      = 1'b0;
        last_access = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    last_access = 1'b1;
                    state_d     = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        we_d = accept ? req_we : we_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
        end
    end

    // Outputs are decoded from the next state and registered, so pins never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            RAMCS     <= 1'b1;
            RAMOE     <= 1'b1;
            RAMWE     <= 1'b1;
            DAT_OE    <= 1'b0;
            ADR       <= '0;
            DAT_O     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            req_ready <= (state_d == IDLE);
            RAMCS     <= (state_d == IDLE);
            RAMOE     <= ~((state_d == ACCESS) && !we_d);
            RAMWE     <= ~((state_d == ACCESS) && we_d);
            DAT_OE    <= we_d && (state_d != IDLE);
            rsp_valid <= (state_d == HOLD);
            if (accept) begin
                ADR <= req_addr;
                if (req_we) begin
                    DAT_O <= req_wdata;
                end
            end
            if (last_access && !we_q) begin
                rsp_rdata <= DAT_I;
            end
        end
    end

`ifdef SRAM_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (rsp_valid) begin
            if (we_q) begin
                wr_count <= wr_count + 32'd1;
            end else begin
                rd_count <= rd_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: three instances (WAIT_CYCLES 2, 1, 15) against an SRAM model
// and a command-level reference memory.
module tb_sram_ctrl;

    function automatic int wc_of(input int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : 15;
    endfunction

    function automatic int key(input int g, input logic [18:0] a);
        return g * (1 << 19) + int'(a);
    endfunction

    typedef struct {
        int          lat;
        int          we_low;
        int          oe_low;
        int          oe_hi;
        int          adr_bad;
        logic [15:0] rdata;
        logic        idle_after;
    } meas_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [18:0] req_addr  [3];
    logic [15:0] req_wdata [3];
    logic        rsp_valid [3];
    logic [15:0] rsp_rdata [3];
    logic [18:0] ram_adr   [3];
    logic [15:0] dat_o     [3];
    logic        dat_oe    [3];
    logic [15:0] dat_i     [3];
    logic        ram_oe_n  [3];
    logic        ram_we_n  [3];
    logic        ram_cs_n  [3];
`ifdef SRAM_CTRL_PERF_EN
    logic [31:0] rd_count  [3];
    logic [31:0] wr_count  [3];
`endif

    int          checks = 0;
    int          errors = 0;
    logic [15:0] sram_mem [3][1 << 19];
    logic [15:0] ref_mem [int];
    logic [15:0] exp_rdata [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sram_ctrl #(.WAIT_CYCLES(wc_of(g))) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_rdata (rsp_rdata[g]),
            .ADR       (ram_adr[g]),
            .DAT_O     (dat_o[g]),
            .DAT_OE    (dat_oe[g]),
            .DAT_I     (dat_i[g]),
            .RAMOE     (ram_oe_n[g]),
            .RAMWE     (ram_we_n[g]),
            .RAMCS     (ram_cs_n[g])
`ifdef SRAM_CTRL_PERF_EN
            ,
            .rd_count  (rd_count[g]),
            .wr_count  (wr_count[g])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM device: stores on write strobe (garbage if the bus is not driven).
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (!ram_we_n[g] && !ram_cs_n[g]) begin
                sram_mem[g][ram_adr[g]] <= dat_oe[g] ? dat_o[g] : 16'h0bad;
            end
        end
    end

    always_comb begin
        for (int g = 0; g < 3; g++) begin
            dat_i[g] = (!ram_oe_n[g] && !ram_cs_n[g]) ? sram_mem[g][ram_adr[g]] : 16'hdead;
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (!ram_oe_n[g] && !ram_we_n[g]) begin
                errors++;
                $display("FAIL strobe_excl inst %0d: RAMOE=0 and RAMWE=0 together at %0t", g, $time);
            end
            if (dat_oe[g] && !ram_oe_n[g]) begin
                errors++;
                $display("FAIL oe_contention inst %0d: DAT_OE=1 while RAMOE=0 at %0t", g, $time);
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_cmd(input int g, input logic we, input logic [18:0] addr,
                           input logic [15:0] wdata, output meas_t m);
        int budget;
        m = '{default: 0};
        @(negedge clk);
        req_valid[g] = 1'b1;
        req_we[g]    = we;
        req_addr[g]  = addr;
        req_wdata[g] = wdata;
        budget = 0;
        while (!req_ready[g] && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (!req_ready[g]) begin
            errors++;
            $display("FAIL accept_timeout inst %0d: req_ready got 0 expected 1", g);
            req_valid[g] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid[g] = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!ram_we_n[g]) m.we_low++;
            if (!ram_oe_n[g]) m.oe_low++;
            if (dat_oe[g])    m.oe_hi++;
            if (ram_adr[g] !== addr) m.adr_bad++;
            if (rsp_valid[g]) begin
                m.lat   = c;
                m.rdata = rsp_rdata[g];
                break;
            end
        end
        @(negedge clk);
        m.idle_after = req_ready[g] && !rsp_valid[g];
    endtask

    task automatic test_reset();
        for (int g = 0; g < 3; g++) begin
            req_valid[g] = 1'b0;
            req_we[g]    = 1'b0;
            req_addr[g]  = '0;
            req_wdata[g] = '0;
            exp_rdata[g] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if ({ram_oe_n[g], ram_we_n[g], ram_cs_n[g], dat_oe[g], rsp_valid[g]} !== 5'b11100) begin
                errors++;
                $display("FAIL reset_strobes inst %0d: got %b expected 11100", g,
                         {ram_oe_n[g], ram_we_n[g], ram_cs_n[g], dat_oe[g], rsp_valid[g]});
            end
            checks++;
            if (ram_adr[g] !== 19'h0 || dat_o[g] !== 16'h0 || rsp_rdata[g] !== 16'h0) begin
                errors++;
                $display("FAIL reset_data inst %0d: ADR=%h DAT_O=%h rdata=%h expected all 0", g,
                         ram_adr[g], dat_o[g], rsp_rdata[g]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (req_ready[g] !== 1'b1) begin
                errors++;
                $display("FAIL ready_after_reset inst %0d: got %b expected 1", g, req_ready[g]);
            end
        end
    endtask

    task automatic test_write_read();
        meas_t m;
        run_cmd(0, 1'b1, 19'h12345, 16'hBEEF, m);
        ref_mem[key(0, 19'h12345)] = 16'hBEEF;
        checks++;
        if (m.adr_bad != 0) begin errors++; $display("FAIL wr_adr: %0d cycles wrong ADR expected 0", m.adr_bad); end
        checks++;
        if (m.we_low != 2) begin errors++; $display("FAIL wr_ramwe_low: got %0d expected 2", m.we_low); end
        checks++;
        if (m.oe_low != 0) begin errors++; $display("FAIL wr_ramoe_low: got %0d expected 0", m.oe_low); end
        checks++;
        if (m.oe_hi != 4) begin errors++; $display("FAIL wr_dat_oe_cycles: got %0d expected 4", m.oe_hi); end
        checks++;
        if (m.lat != 4) begin errors++; $display("FAIL wr_latency: got %0d expected 4", m.lat); end
        checks++;
        if (m.rdata !== exp_rdata[0]) begin errors++; $display("FAIL wr_rdata_kept: got %h expected %h", m.rdata, exp_rdata[0]); end
        checks++;
        if (!m.idle_after) begin errors++; $display("FAIL wr_idle_after: got 0 expected 1"); end

        run_cmd(0, 1'b0, 19'h12345, 16'h0000, m);
        exp_rdata[0] = 16'hBEEF;
        checks++;
        if (m.oe_low != 2) begin errors++; $display("FAIL rd_ramoe_low: got %0d expected 2", m.oe_low); end
        checks++;
        if (m.oe_hi != 0 || m.we_low != 0) begin
            errors++;
            $display("FAIL rd_no_drive: DAT_OE cycles %0d RAMWE-low %0d expected 0 0", m.oe_hi, m.we_low);
        end
        checks++;
        if (m.lat != 4) begin errors++; $display("FAIL rd_latency: got %0d expected 4", m.lat); end
        checks++;
        if (m.rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_data: got %h expected beef", m.rdata); end
    endtask

    task automatic test_random();
        meas_t       m;
        logic [18:0] pool [6];
        logic [18:0] a;
        logic [15:0] d;
        logic        we;
        for (int i = 0; i < 6; i++) pool[i] = 19'($urandom);
        for (int i = 0; i < 24; i++) begin
            a  = pool[$urandom_range(0, 5)];
            d  = 16'($urandom);
            we = !ref_mem.exists(key(0, a)) || ($urandom_range(0, 1) == 1);
            run_cmd(0, we, a, d, m);
            if (we) ref_mem[key(0, a)] = d;
            else    exp_rdata[0] = ref_mem[key(0, a)];
            checks++;
            if (m.lat != 4 || !m.idle_after || m.adr_bad != 0) begin
                errors++;
                $display("FAIL rnd_timing op %0d: lat=%0d idle=%b adr_bad=%0d expected 4 1 0",
                         i, m.lat, m.idle_after, m.adr_bad);
            end
            checks++;
            if ((we ? m.we_low : m.oe_low) != 2) begin
                errors++;
                $display("FAIL rnd_strobe op %0d we=%b: got %0d low cycles expected 2", i, we,
                         we ? m.we_low : m.oe_low);
            end
            checks++;
            if (m.rdata !== exp_rdata[0]) begin
                errors++;
                $display("FAIL rnd_rdata op %0d we=%b addr %h: got %h expected %h", i, we, a,
                         m.rdata, exp_rdata[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] b_addr [10];
        logic [15:0] b_data [10];
        logic        b_we   [10];
        int          acc_cyc [10];
        logic [15:0] exp_q [$];
        logic [15:0] last;
        logic [18:0] base;
        logic [15:0] e;
        int          n_acc;
        int          n_rsp;
        base = 19'($urandom);
        last = exp_rdata[0];
        for (int i = 0; i < 10; i++) begin
            b_we[i]   = (i < 5);
            b_addr[i] = base + 19'(i % 5);
            b_data[i] = (i < 5) ? 16'($urandom) : b_data[i - 5];
            if (!b_we[i]) last = b_data[i];
            else ref_mem[key(0, b_addr[i])] = b_data[i];
            exp_q.push_back(last);
        end
        exp_rdata[0] = last;
        n_acc = 0;
        n_rsp = 0;
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = b_we[0];
        req_addr[0]  = b_addr[0];
        req_wdata[0] = b_data[0];
        for (int cyc = 0; cyc < 200 && (n_acc < 10 || n_rsp < 10); cyc++) begin
            if (rsp_valid[0]) begin
                n_rsp++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra_rsp: response %0d with none outstanding", n_rsp);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_rdata[0] !== e) begin
                        errors++;
                        $display("FAIL b2b_rdata rsp %0d: got %h expected %h", n_rsp, rsp_rdata[0], e);
                    end
                end
            end
            if (req_valid[0] && req_ready[0]) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                @(posedge clk);
                #1;
                if (n_acc < 10) begin
                    req_we[0]    = b_we[n_acc];
                    req_addr[0]  = b_addr[n_acc];
                    req_wdata[0] = b_data[n_acc];
                end else begin
                    req_valid[0] = 1'b0;
                end
            end
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        checks++;
        if (n_acc != 10 || n_rsp != 10) begin
            errors++;
            $display("FAIL b2b_counts: accepts %0d responses %0d expected 10 10", n_acc, n_rsp);
        end
        for (int i = 1; i < n_acc; i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i - 1] != 5) begin
                errors++;
                $display("FAIL b2b_rate accept %0d: spacing %0d expected 5", i, acc_cyc[i] - acc_cyc[i - 1]);
            end
        end
    endtask

    task automatic test_wait_sweep();
        meas_t       m;
        logic [18:0] a;
        logic [15:0] d;
        int          w;
        for (int g = 1; g < 3; g++) begin
            w = wc_of(g);
            a = 19'($urandom);
            d = 16'($urandom);
            run_cmd(g, 1'b1, a, d, m);
            checks++;
            if (m.we_low != w || m.lat != w + 2 || m.oe_hi != w + 2) begin
                errors++;
                $display("FAIL sweep_wr W=%0d: RAMWE-low %0d lat %0d DAT_OE %0d expected %0d %0d %0d",
                         w, m.we_low, m.lat, m.oe_hi, w, w + 2, w + 2);
            end
            run_cmd(g, 1'b0, a, 16'h0, m);
            checks++;
            if (m.oe_low != w || m.lat != w + 2) begin
                errors++;
                $display("FAIL sweep_rd W=%0d: RAMOE-low %0d lat %0d expected %0d %0d",
                         w, m.oe_low, m.lat, w, w + 2);
            end
            checks++;
            if (m.rdata !== d) begin
                errors++;
                $display("FAIL sweep_rdata W=%0d: got %h expected %h", w, m.rdata, d);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [18:0] a;
        int          budget;
        int          seen_rsp;
        a = 19'h7_0F0F;
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = a;
        req_wdata[0] = 16'h5A5A;
        budget = 0;
        while (!req_ready[0] && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ram_we_n[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_in_access: RAMWE got %b expected 0", ram_we_n[0]);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({ram_we_n[0], ram_cs_n[0], dat_oe[0]} !== 3'b110) begin
            errors++;
            $display("FAIL abort_immediate: RAMWE,RAMCS,DAT_OE got %b expected 110",
                     {ram_we_n[0], ram_cs_n[0], dat_oe[0]});
        end
        seen_rsp = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid[0]) seen_rsp++;
        end
        rst_n = 1'b1;
        for (int g = 0; g < 3; g++) exp_rdata[g] = '0;
        ref_mem.delete(key(0, a));
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid[0]) seen_rsp++;
        end
        checks++;
        if (seen_rsp != 0) begin
            errors++;
            $display("FAIL abort_no_rsp: rsp_valid seen %0d cycles expected 0", seen_rsp);
        end
        checks++;
        if (req_ready[0] !== 1'b1 || rsp_rdata[0] !== 16'h0) begin
            errors++;
            $display("FAIL abort_release: req_ready %b rdata %h expected 1 0000", req_ready[0], rsp_rdata[0]);
        end
    endtask

`ifdef SRAM_CTRL_PERF_EN
    task automatic test_perf();
        meas_t       m;
        logic [18:0] a;
        checks++;
        if (rd_count[0] !== 32'd0 || wr_count[0] !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset: rd %0d wr %0d expected 0 0", rd_count[0], wr_count[0]);
        end
        a = 19'h0_1234;
        run_cmd(0, 1'b1, a, 16'h1111, m);
        for (int i = 0; i < 3; i++) run_cmd(0, 1'b0, a, 16'h0, m);
        run_cmd(0, 1'b1, a + 19'd1, 16'h2222, m);
        checks++;
        if (rd_count[0] !== 32'd3 || wr_count[0] !== 32'd2) begin
            errors++;
            $display("FAIL perf_counts: rd %0d wr %0d expected 3 2", rd_count[0], wr_count[0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_random();
        test_back_to_back();
        test_wait_sweep();
        test_reset_mid();
`ifdef SRAM_CTRL_PERF_EN
        test_perf();
`endif
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
